// File: rtl/irq_nmi_ctrl_if.sv
// CPU-side bus of the interrupt/reset controller: address, control and the three CPU request lines.
// The data bus stays a plain inout on the controller so tristate resolution happens on a single net.
interface irq_nmi_ctrl_if;
  logic [7:0] abh;
  logic [7:0] abl;
  logic       rw;
  logic       sync;
  logic       cpuclr;
  logic       irq;
  logic       nmi;

  modport master (output abh, abl, rw, sync, input cpuclr, irq, nmi);
  modport slave  (input abh, abl, rw, sync, output cpuclr, irq, nmi);
endinterface

// File: rtl/irq_nmi_ctrl.sv
// Interrupt/reset controller for the 6502: reset stretcher, 4 edge-latched masked IRQs, NMI edge detector.
// Register reads are combinational on dataio; writes and all state updates land on the rising clk edge.
module irq_nmi_ctrl #(
  parameter logic [15:0] BASE   = 16'hFE00,
  parameter int          RSTLEN = 4,
  parameter int          NSRC   = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            rst_req,
  input  logic [NSRC-1:0] irq_src,
  input  logic            nmi_n,
  inout  wire  [7:0]      dataio,
  irq_nmi_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT1 = 2'd1;
  localparam logic [1:0] ASSERT2 = 2'd2;

  logic [3:0]      cnt;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            irq_r;
  logic            s1, s2, hist;
  logic [1:0]      state;
  logic [7:0]      nmicnt;

  logic [15:0]     off;
  logic            in_win;
  logic            wr_en;
  logic            rd_en;
  logic [7:0]      rd_dat;
  logic [7:0]      prio;
  logic [NSRC-1:0] pm;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_nxt;
  logic            fall;
  logic            cpuclr;

  // Subtracting BASE keeps the window decode correct even for an unaligned BASE.
  assign off    = {bus.abh, bus.abl} - BASE;
  assign in_win = (off[15:2] == 14'd0);
  assign wr_en  = in_win & ~bus.rw;
  assign rd_en  = in_win & bus.rw;

  assign cpuclr = (cnt != 4'd0);
  assign pm     = pending & mask;
  assign rise   = irq_src & ~prev;
  assign fall   = hist & ~s2;

  // A new edge on a bit outranks a simultaneous software clear of that bit.
  always_comb begin
    pend_nxt = pending;
    if (wr_en && off[1:0] == 2'd0)
      pend_nxt = pending & ~dataio[NSRC-1:0];
    pend_nxt = pend_nxt | rise;
  end

  always_comb begin
    prio = 8'hFF;
    for (int i = NSRC-1; i >= 0; i--)
      if (pm[i]) prio = 8'(i);
  end

  always_comb begin
    rd_dat = 8'h00;
    case (off[1:0])
      2'd0:    rd_dat = 8'(pending);
      2'd1:    rd_dat = 8'(mask);
      2'd2:    rd_dat = prio;
      default: rd_dat = nmicnt;
    endcase
  end

  assign dataio = rd_en ? rd_dat : 8'bz;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= 4'(RSTLEN);
      prev    <= '0;
      pending <= '0;
      mask    <= '0;
      irq_r   <= 1'b0;
      s1      <= 1'b1;
      s2      <= 1'b1;
      hist    <= 1'b1;
      state   <= IDLE;
      nmicnt  <= 8'd0;
    end else begin
      prev <= irq_src;
      s1   <= nmi_n;
      s2   <= s1;
      hist <= s2;

      if (rst_req)
        cnt <= 4'(RSTLEN);
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;

      // mask survives a CPU clear; only clr resets it.
      if (wr_en && off[1:0] == 2'd1)
        mask <= dataio[NSRC-1:0];

      if (cpuclr) begin
        pending <= '0;
        irq_r   <= 1'b0;
        state   <= IDLE;
      end else begin
        pending <= pend_nxt;
        irq_r   <= |pm;
        case (state)
          IDLE: begin
            if (fall) begin
              state  <= ASSERT1;
              nmicnt <= nmicnt + 8'd1;
            end
          end
          ASSERT1: state <= ASSERT2;
          ASSERT2: if (bus.sync) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cpuclr = cpuclr;
  assign bus.irq    = irq_r;
  assign bus.nmi    = (state != IDLE);

endmodule

// File: tb/tb_irq_nmi_ctrl.sv
// Directed plus randomized bench for irq_nmi_ctrl, scored against a cycle-level behavioural model.
module tb_irq_nmi_ctrl;
  localparam logic [15:0] BASE   = 16'hFE00;
  localparam int          RSTLEN = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       rst_req = 1'b0;
  logic [3:0] irq_src = 4'h0;
  logic       nmi_n = 1'b1;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_dat = 8'h00;
  wire  [7:0] dataio;

  irq_nmi_ctrl_if bus();

  assign dataio = tb_drv ? tb_dat : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (dataio[g]);
  end

  irq_nmi_ctrl #(.BASE(BASE), .RSTLEN(RSTLEN), .NSRC(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .rst_req (rst_req),
    .irq_src (irq_src),
    .nmi_n   (nmi_n),
    .dataio  (dataio),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  logic [7:0] last_rd;

  // Reference model: cycles of CPU clear left, pending/mask sets, NMI age in cycles, sample history.
  int         m_left;
  logic [3:0] m_pend, m_mask, m_prev;
  logic       m_irq;
  int         m_age;
  logic [7:0] m_cnt;
  bit         nq[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [1:0] o);
    logic [7:0] v;
    v = 8'hFF;
    case (o)
      2'd0: v = {4'h0, m_pend};
      2'd1: v = {4'h0, m_mask};
      2'd2: begin
        for (int i = 3; i >= 0; i--)
          if (m_pend[i] && m_mask[i]) v = 8'(i);
      end
      default: v = m_cnt;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    logic [15:0] o;
    logic        wr, busy, fall;
    logic [3:0]  rise, old_pm;
    o  = {bus.abh, bus.abl} - BASE;
    wr = (o < 16'd4) && !bus.rw;
    if (clr) begin
      m_left = RSTLEN; m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'h0;
      m_irq = 1'b0; m_age = 0; m_cnt = 8'h00;
      nq = '{1'b1, 1'b1, 1'b1};
    end else begin
      busy   = (m_left > 0);
      fall   = (nq[2] == 1'b1) && (nq[1] == 1'b0);
      rise   = irq_src & ~m_prev;
      old_pm = m_pend & m_mask;
      if (busy) begin
        m_pend = 4'h0; m_irq = 1'b0; m_age = 0;
      end else begin
        if (wr && o[1:0] == 2'd0) m_pend = m_pend & ~tb_dat[3:0];
        m_pend = m_pend | rise;
        m_irq  = |old_pm;
        if (m_age == 0) begin
          if (fall) begin m_age = 1; m_cnt = m_cnt + 8'd1; end
        end else if (m_age >= 2 && bus.sync) m_age = 0;
        else m_age = m_age + 1;
      end
      if (wr && o[1:0] == 2'd1) m_mask = tb_dat[3:0];
      if (rst_req) m_left = RSTLEN;
      else if (m_left > 0) m_left = m_left - 1;
      m_prev = irq_src;
      nq.push_front(nmi_n);
      void'(nq.pop_back());
    end
  endtask

  // One clock: check the combinational read, take the edge, then check the registered outputs.
  task automatic cycle();
    logic [15:0] o;
    #2;
    o = {bus.abh, bus.abl} - BASE;
    last_rd = dataio;
    if (!tb_drv) begin
      if (o < 16'd4) chk("rd_dat", dataio, mread(o[1:0]));
      else begin
        nchk++;
        assert ((dataio === 8'hzz) || (dataio === 8'hFF)) npass++;
        else begin
          nfail++;
          $error("FAIL dataio_z observed=%h expected=zz", dataio);
        end
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("cpuclr", 8'(bus.cpuclr), 8'(m_left > 0));
    chk("irq", 8'(bus.irq), 8'(m_irq));
    chk("nmi", 8'(bus.nmi), 8'(m_age > 0));
  endtask

  task automatic set_idle();
    {bus.abh, bus.abl} = 16'h1234;
    bus.rw = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    {bus.abh, bus.abl} = BASE + 16'(o);
    bus.rw = 1'b0; tb_drv = 1'b1; tb_dat = d;
    cycle();
    set_idle();
  endtask

  task automatic rd(input logic [1:0] o);
    {bus.abh, bus.abl} = BASE + 16'(o);
    bus.rw = 1'b1; tb_drv = 1'b0;
    cycle();
    set_idle();
  endtask

  initial begin
    logic [15:0] a;
    int r;
    set_idle();
    bus.sync = 1'b0;

    // reset stretch
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("clr_cpuclr", 8'(bus.cpuclr), 8'h01);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("stretch", 8'(bus.cpuclr), 8'(k < 4));
    end
    chk("rst_irq", 8'(bus.irq), 8'h00);
    chk("rst_nmi", 8'(bus.nmi), 8'h00);

    // restart mid-stretch
    clr = 1'b1; cycle(); clr = 1'b0;
    cycle(); cycle();
    rst_req = 1'b1; cycle(); rst_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("restart", 8'(bus.cpuclr), 8'(k < 4));
    end

    // masked IRQ on source 2
    wr(2'd1, 8'h04);
    irq_src = 4'b0100; cycle();
    chk("irq_lag", 8'(bus.irq), 8'h00);
    irq_src = 4'b0000; cycle();
    chk("irq_set", 8'(bus.irq), 8'h01);
    rd(2'd0); chk("pend_04", last_rd, 8'h04);
    rd(2'd2); chk("prio_02", last_rd, 8'h02);
    wr(2'd0, 8'h04);
    cycle();
    chk("irq_clr", 8'(bus.irq), 8'h00);

    // mask blocks, then priority
    wr(2'd1, 8'h00);
    irq_src = 4'b0001; cycle(); irq_src = 4'b0000;
    cycle(); cycle();
    chk("irq_masked", 8'(bus.irq), 8'h00);
    rd(2'd2); chk("prio_ff", last_rd, 8'hFF);
    wr(2'd0, 8'h0F);
    irq_src = 4'b1010; cycle(); irq_src = 4'b0000;
    wr(2'd1, 8'h0F);
    rd(2'd2); chk("prio_01", last_rd, 8'h01);
    rd(2'd0); chk("pend_0a", last_rd, 8'h0A);

    // NMI with absorbed second fall
    nmi_n = 1'b0;
    cycle(); chk("nmi_d1", 8'(bus.nmi), 8'h00);
    cycle(); chk("nmi_d2", 8'(bus.nmi), 8'h00);
    cycle(); chk("nmi_on", 8'(bus.nmi), 8'h01);
    nmi_n = 1'b1; repeat (4) cycle();
    nmi_n = 1'b0; repeat (4) cycle();
    chk("nmi_hold", 8'(bus.nmi), 8'h01);
    bus.sync = 1'b1; cycle(); bus.sync = 1'b0;
    chk("nmi_off", 8'(bus.nmi), 8'h00);
    rd(2'd3); chk("nmicnt_01", last_rd, 8'h01);

    // set beats clear on the same bit
    irq_src = 4'b0010;
    wr(2'd0, 8'h02);
    irq_src = 4'b0000;
    rd(2'd0); chk("collide", last_rd, 8'h0A);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      clr      = ($urandom_range(0, 299) == 0);
      rst_req  = ($urandom_range(0, 99) == 0);
      irq_src  = irq_src ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
      bus.sync = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      if (r < 40) begin
        a = 16'($urandom);
        if ((a - BASE) < 16'd4) a = 16'h0000;
        {bus.abh, bus.abl} = a;
        bus.rw = 1'b1; tb_drv = 1'b0;
      end else if (r < 70) begin
        {bus.abh, bus.abl} = BASE + 16'($urandom_range(0, 3));
        bus.rw = 1'b1; tb_drv = 1'b0;
      end else begin
        {bus.abh, bus.abl} = BASE + 16'($urandom_range(0, 3));
        bus.rw = 1'b0; tb_drv = 1'b1; tb_dat = 8'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/irq_nmi_ctrl.md
Name: irq_nmi_ctrl

Overview:
- Interrupt and reset controller sitting directly upstream of the 6502 board; drives the CPU's clr, irq and nmi inputs.
- Edge-latches 4 external IRQ sources into a pending register and masks them; irq is the OR of pending & mask.
- Detects falling edges on an external NMI line and stretches reset requests into a clean multi-cycle CPU clear.
- Software access is through a small memory-mapped register window on the CPU bus (abh/abl/dataio/rw).

Parameters:
BASE, 16'hFE00, address of register 0; the window is BASE..BASE+3.
RSTLEN, 4, number of clk cycles cpuclr is held after a reset request (1..15).
NSRC, 4, number of IRQ sources (fixed at 4 in this revision).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clr  input  1  synchronous, active-high reset of this block.
rst_req  input  1  synchronous reset request (button/watchdog), active-high.
irq_src  input  4  raw IRQ source lines, rising-edge sensitive.
nmi_n  input  1  raw NMI line, falling-edge sensitive, asynchronous.
abh  input  8  CPU address bus, high byte.
abl  input  8  CPU address bus, low byte.
rw  input  1  CPU read/write; 1 = read.
sync  input  1  CPU opcode-fetch indicator.
dataio  inout  8  CPU data bus; driven only during a register read, otherwise Z.
cpuclr  output  1  clear to the CPU, active-high.
irq  output  1  maskable interrupt request to the CPU, active-high level.
nmi  output  1  non-maskable interrupt request to the CPU, active-high.

Behaviour:
- Reset (clr=1 at a clk edge):
  - pending=0, mask=0, nmi=0, irq=0, edge-detect history=0.
  - NMI synchroniser flops set to 1 (idle high).
  - cpuclr=1 and the stretch counter is loaded with RSTLEN.
- Reset stretcher:
  - rst_req=1 at an edge reloads the counter with RSTLEN and sets cpuclr=1.
  - Otherwise, while the counter is nonzero it decrements, and cpuclr=1.
  - cpuclr falls on the edge where the counter reaches 0. After clr or rst_req deassert, cpuclr is high for exactly RSTLEN cycles.
  - A rst_req arriving mid-stretch restarts the count.
  - While cpuclr=1: pending, nmi and irq are forced to 0. mask is not cleared (only clr clears mask).
- IRQ capture:
  - irq_src is registered once (prev). A source sets pending[i] on the edge where irq_src[i]=1 and prev[i]=0.
  - irq = |(pending & mask), registered, so it appears 1 cycle after pending updates.
- Register map (addr = {abh,abl}):
  - BASE+0 PEND: read returns {4'b0,pending}; a write of 1 to bit i clears pending[i].
  - BASE+1 MASK: read/write, low 4 bits; upper bits read 0.
  - BASE+2 PRIO: read-only; returns the index 0..3 of the lowest-numbered bit of pending&mask, or 8'hFF if none.
  - BASE+3 NMICNT: read-only 8-bit count of NMIs taken, wrapping 255->0; cleared by clr only.
  - Writes to PRIO and NMICNT are ignored.
- Bus timing:
  - A write occurs on the rising clk edge where rw=0 and the address is in the window; the data written is dataio.
  - A read drives dataio combinationally while rw=1 and the address is in the window.
  - Outside the window, dataio stays Z.
- PEND write vs. new edge: if a PEND clear-write and a new edge on the same bit occur in the same cycle, the set wins.
- NMI:
  - nmi_n passes through a 2-flop synchroniser (s1, s2) plus one history flop.
  - A falling edge (history=1, s2=0) sets nmi=1 and increments NMICNT.
  - nmi stays 1 until the first cycle after the edge where sync=1, with a minimum high time of 2 cycles; it clears on the following edge.
  - A new falling edge while nmi=1 is absorbed (no second count, no extension).
- State machine for NMI: IDLE -> (fall) ASSERT1 -> ASSERT2 -> (sync) IDLE.
  - ASSERT2 is held while sync=0.
  - cpuclr forces the state to IDLE.

Test Plan:
- Reset and stretch: clr=1 for 1 cycle, then 0 -> cpuclr=1 for 4 cycles then 0; irq=0, nmi=0; dataio=Z at an address outside the window.
- Mid-stretch restart: rst_req pulse 2 cycles after cpuclr begins its count -> cpuclr high for 4 more cycles from that pulse.
- Masked IRQ:
  - Write MASK(FE01)=8'h04, then pulse irq_src[2] -> PEND reads 8'h04; irq=1 one cycle after pending sets; PRIO reads 8'h02.
  - Write PEND=8'h04 -> irq=0 on the next cycle.
- Mask block and priority:
  - Pulse irq_src[0] with mask=4'h0 -> irq stays 0; PRIO reads 8'hFF.
  - Set mask=4'hF with pending=4'b1010 -> PRIO reads 8'h01.
- NMI:
  - Drive nmi_n 1->0 with sync=0 -> nmi=1 three cycles later, held until sync=1, then cleared; NMICNT reads 8'h01.
  - A second fall while nmi=1 -> NMICNT is still 8'h01.
- Collision: PEND clear-write of bit 1 in the same cycle as a rising edge on irq_src[1] -> pending[1] remains 1.
